dir_input: RTL and testbench

DIR_INPUT -- requirements
Module: dir_input

---
 rtl/dir_input.sv | 141 ++++++++++++++
 tb/tb_dir_input.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_input.sv
// dir_input: debounces four active-low pushbuttons and issues one-hot move requests.
// Optional macro DIR_AUTO_REPEAT_EN re-issues a held key every REPEAT_CYCLES after move_done.
module dir_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_n,
    input  logic       enable,
    input  logic       move_done,
    output logic [3:0] direction,
    output logic       busy
);

    localparam int unsigned MaxCycles =
        (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles) + 1;
    localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRel} state_e;

    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      db_q, db_d;
    logic [CntW-1:0] cnt_q [4];
    logic [CntW-1:0] cnt_d [4];

    state_e     state_q;
    logic [3:0] dir_q;
    logic       busy_q;
    logic [3:0] pressed;
    logic       single;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            db_q    <= 4'hF;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Count consecutive cycles the synchronized level disagrees; flip on the Nth.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign pressed = ~db_q;
    assign single  = (pressed != 4'd0) && ((pressed & (pressed - 4'd1)) == 4'd0);

`ifdef DIR_AUTO_REPEAT_EN
    localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);

    logic [CntW-1:0] rep_cnt_q;
    logic            rep_arm_q;
    logic            db_chg;

    assign db_chg = (db_d != db_q);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            dir_q     <= 4'd0;
            busy_q    <= 1'b0;
`ifdef DIR_AUTO_REPEAT_EN
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
`endif
        end else begin
`ifdef DIR_AUTO_REPEAT_EN
            // Age of the current held-key pattern since move_done, saturating.
            if (db_chg || (state_q != StWaitRel)) begin
                rep_cnt_q <= '0;
            end else if (rep_cnt_q != RepLast) begin
                rep_cnt_q <= rep_cnt_q + CntW'(1);
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (enable && single) begin
                        dir_q   <= pressed;
                        busy_q  <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (move_done) begin
                        dir_q     <= 4'd0;
                        state_q   <= StWaitRel;
`ifdef DIR_AUTO_REPEAT_EN
                        rep_arm_q <= 1'b1;
`endif
                    end else if (!enable) begin
                        dir_q     <= 4'd0;
                        state_q   <= StWaitRel;
`ifdef DIR_AUTO_REPEAT_EN
                        rep_arm_q <= 1'b0;
`endif
                    end
                end
                StWaitRel: begin
                    if (pressed == 4'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
`ifdef DIR_AUTO_REPEAT_EN
                    else if (rep_arm_q && enable && single && (rep_cnt_q == RepLast)) begin
                        dir_q   <= pressed;
                        state_q <= StIssue;
                    end
`endif
                end
                default: begin
                    dir_q   <= 4'd0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign direction = dir_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dir_input.sv
// Bench for dir_input: vector table, directed corner sequences and a random run
// cross-checked every cycle against a sliding-window reference model.
module tb_dir_input;

    localparam int unsigned D = 4;
    localparam int unsigned R = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       enable = 1'b0;
    logic       move_done = 1'b0;
    logic [3:0] direction;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    dir_input #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_n    (key_n),
        .enable   (enable),
        .move_done(move_done),
        .direction(direction),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a key's debounced level flips when the last D synchronized
    // samples all disagree with it; requests follow the press/ack/release rules.
    int         m_st;            // 0 idle, 1 issuing, 2 waiting for release
    logic [3:0] m_h1, m_h2, m_db, m_dir;
    logic [3:0] sq[$];
    int         m_edge = 0;
    int         m_mark = 0;
    bit         m_arm;

    function automatic void model_step();
        logic [3:0] pr, nd;
        bit         one;
        m_edge++;
        if (!reset_n) begin
            m_h1 = 4'hF; m_h2 = 4'hF; m_db = 4'hF; m_dir = 4'd0;
            m_st = 0; m_arm = 1'b0;
            sq.delete();
            return;
        end
        pr  = ~m_db;
        one = ($countones(pr) == 1);
        case (m_st)
            0: if (enable && one) begin m_dir = pr; m_st = 1; end
            1: begin
                if (move_done) begin
                    m_dir = 4'd0; m_st = 2; m_arm = 1'b1; m_mark = m_edge;
                end else if (!enable) begin
                    m_dir = 4'd0; m_st = 2; m_arm = 1'b0;
                end
            end
            default: begin
                if (pr == 4'd0) m_st = 0;
`ifdef DIR_AUTO_REPEAT_EN
                else if (m_arm && enable && one && (m_edge - m_mark >= int'(R))) begin
                    m_dir = pr; m_st = 1;
                end
`endif
            end
        endcase
        sq.push_back(m_h2);
        if (sq.size() > D) void'(sq.pop_front());
        nd = m_db;
        if (sq.size() == D) begin
            for (int i = 0; i < 4; i++) begin
                int diff;
                diff = 0;
                foreach (sq[j]) if (sq[j][i] != m_db[i]) diff++;
                if (diff == int'(D)) nd[i] = ~m_db[i];
            end
        end
        if (nd != m_db) m_mark = m_edge;
        m_db = nd;
        m_h2 = m_h1;
        m_h1 = key_n;
    endfunction

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dir", direction, m_dir);
            check("model_busy", {3'b0, busy}, {3'b0, (m_st != 0)});
        end
    end

    typedef struct packed {
        logic [3:0] key_n;
        logic       en;
        logic       md;
        logic [7:0] cyc;
        logic [3:0] dir;
        logic       bsy;
    } vec_t;

    vec_t vec [12];

    // A key_n change is sampled by the next edge (cycle 0); the synchronizer output is
    // valid after edge 2, the level flips after D more, and direction follows one edge later.
    initial begin
        vec[0]  = '{4'hE, 1'b1, 1'b0, 8'd6,  4'b0000, 1'b0};
        vec[1]  = '{4'hE, 1'b1, 1'b0, 8'd1,  4'b0001, 1'b1};
        vec[2]  = '{4'hE, 1'b1, 1'b1, 8'd1,  4'b0000, 1'b1};
        vec[3]  = '{4'hE, 1'b1, 1'b0, 8'd10, 4'b0000, 1'b1};
        vec[4]  = '{4'hF, 1'b1, 1'b0, 8'd6,  4'b0000, 1'b1};
        vec[5]  = '{4'hF, 1'b1, 1'b0, 8'd1,  4'b0000, 1'b0};
        vec[6]  = '{4'hC, 1'b1, 1'b0, 8'd40, 4'b0000, 1'b0};
        vec[7]  = '{4'hF, 1'b1, 1'b0, 8'd10, 4'b0000, 1'b0};
        vec[8]  = '{4'hD, 1'b1, 1'b0, 8'd7,  4'b0010, 1'b1};
        vec[9]  = '{4'hD, 1'b0, 1'b0, 8'd1,  4'b0000, 1'b1};
        vec[10] = '{4'hD, 1'b1, 1'b0, 8'd10, 4'b0000, 1'b1};
        vec[11] = '{4'hF, 1'b1, 1'b0, 8'd7,  4'b0000, 1'b0};

        reset_n = 1'b0;
        tick(3);
        chk_en = 1'b1;
        check("reset_dir", direction, 4'd0);
        check("reset_busy", {3'b0, busy}, 4'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        foreach (vec[v]) begin
            key_n     = vec[v].key_n;
            enable    = vec[v].en;
            move_done = vec[v].md;
            tick(int'(vec[v].cyc));
            check($sformatf("vec%0d_dir", v), direction, vec[v].dir);
            check($sformatf("vec%0d_busy", v), {3'b0, busy}, {3'b0, vec[v].bsy});
        end
        move_done = 1'b0;
        enable    = 1'b1;

        // Right key bouncing every 2 cycles never settles long enough.
        for (int s = 0; s < 6; s++) begin
            key_n = (s % 2 == 0) ? 4'hB : 4'hF;
            tick(2);
            check("bounce_quiet", direction, 4'd0);
        end
        key_n = 4'hB;
        tick(6);
        check("bounce_early", direction, 4'd0);
        tick(1);
        check("bounce_dir", direction, 4'b0100);
        move_done = 1'b1;
        tick(1);
        move_done = 1'b0;
        key_n = 4'hF;
        tick(8);
        check("bounce_idle", {3'b0, busy}, 4'd0);

        // Up key held through move_done.
        key_n = 4'h7;
        tick(7);
        check("up_dir", direction, 4'b1000);
        move_done = 1'b1;
        tick(1);
        move_done = 1'b0;
        check("up_ack_dir", direction, 4'd0);
        check("up_ack_busy", {3'b0, busy}, 4'd1);
`ifdef DIR_AUTO_REPEAT_EN
        tick(19);
        check("repeat_early", direction, 4'd0);
        tick(1);
        check("repeat_dir", direction, 4'b1000);
        move_done = 1'b1;
        tick(1);
        move_done = 1'b0;
        check("repeat_ack", direction, 4'd0);
`else
        tick(30);
        check("no_repeat", direction, 4'd0);
        check("no_repeat_busy", {3'b0, busy}, 4'd1);
`endif
        key_n = 4'hF;
        tick(6);
        check("up_rel_busy", {3'b0, busy}, 4'd1);
        tick(1);
        check("up_idle", {3'b0, busy}, 4'd0);

        // Reset while a request is outstanding.
        key_n = 4'hD;
        tick(7);
        check("rst_pre_dir", direction, 4'b0010);
        reset_n = 1'b0;
        tick(1);
        check("rst_dir", direction, 4'd0);
        check("rst_busy", {3'b0, busy}, 4'd0);
        reset_n = 1'b1;
        tick(1);
        check("rst_no_pending", direction, 4'd0);
        key_n = 4'hF;
        tick(10);

        // Random traffic, checked every cycle against the model.
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) key_n = ~(4'd1 << $urandom_range(0, 3));
            else if (r < 8) key_n = 4'hF;
            else key_n = 4'($urandom_range(0, 15));
            enable  = ($urandom_range(0, 9) != 0);
            reset_n = ($urandom_range(0, 49) != 0);
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                move_done = ($urandom_range(0, 5) == 0);
                tick(1);
                reset_n = 1'b1;
            end
        end
        move_done = 1'b0;
        tick(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
